// File: rtl/egr_tcu_tqu_pop_ctrl.sv
// TCU-side pop controller for the TQU->TCU return path: round-robin pop arbitration,
// in-flight tracking of outstanding pops and a credit-protected return FIFO.
module egr_tcu_tqu_pop_ctrl #(
    parameter int NUM_Q      = 36,
    parameter int DATA_W     = 64,
    parameter int POP_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_Q-1:0]         tcu_req,
    input  logic [NUM_Q-1:0]         tqu_data_ready,
    output logic [NUM_Q-1:0]         tcu_pop,
    input  logic                     tqu_data_valid,
    input  logic [DATA_W-1:0]        tqu_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(NUM_Q)-1:0] out_qid,
    input  logic                     out_ready,
    output logic                     err_unexp,
    output logic                     err_miss
);

    localparam int QID_W  = $clog2(NUM_Q);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [QID_W-1:0]  ptr;
    logic [QID_W-1:0]  gnt_idx;
    logic [QID_W-1:0]  pop_qid;
    logic [QID_W-1:0]  cand;
    logic [QID_W:0]    scan_sum;
    logic [NUM_Q-1:0]  elig;
    logic              found;
    logic              grant;

    logic [CRED_W-1:0] credit;
    logic [CRED_W-1:0] credit_nxt;

    logic [POP_LAT-1:0] pipe_v;
    logic [QID_W-1:0]   pipe_q [POP_LAT];
    logic               expected;
    logic [QID_W-1:0]   exp_qid;

    logic              fifo_wr;
    logic              fifo_rd;
    logic              ret_miss;
    logic              ret_unexp;
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [QID_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CRED_W-1:0] fifo_cnt;

    // The queue being popped right now is masked: its ready has not yet seen the pop.
    always_comb begin
        elig     = tcu_req & tqu_data_ready & ~tcu_pop;
        found    = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            scan_sum = {1'b0, ptr} + (QID_W+1)'(i);
            if (scan_sum >= (QID_W+1)'(NUM_Q))
                scan_sum = scan_sum - (QID_W+1)'(NUM_Q);
            cand = scan_sum[QID_W-1:0];
            if (!found && elig[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant = found && (credit != '0);

    assign expected  = pipe_v[POP_LAT-1];
    assign exp_qid   = pipe_q[POP_LAT-1];
    assign fifo_wr   = expected & tqu_data_valid;
    assign ret_miss  = expected & ~tqu_data_valid;
    assign ret_unexp = ~expected & tqu_data_valid;

    assign out_valid = (fifo_cnt != '0);
    assign fifo_rd   = out_valid & out_ready;
    assign out_data  = out_valid ? mem_d[rptr] : '0;
    assign out_qid   = out_valid ? mem_q[rptr] : '0;

    // A missing return frees its reserved slot just like a FIFO read does.
    always_comb begin
        credit_nxt = credit;
        if (grant)
            credit_nxt = credit_nxt - 1'b1;
        if (fifo_rd)
            credit_nxt = credit_nxt + 1'b1;
        if (ret_miss)
            credit_nxt = credit_nxt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcu_pop   <= '0;
            pop_qid   <= '0;
            ptr       <= '0;
            credit    <= CRED_W'(FIFO_DEPTH);
            pipe_v    <= '0;
            for (int s = 0; s < POP_LAT; s++)
                pipe_q[s] <= '0;
            wptr      <= '0;
            rptr      <= '0;
            fifo_cnt  <= '0;
            err_unexp <= 1'b0;
            err_miss  <= 1'b0;
        end else begin
            tcu_pop <= '0;
            if (grant) begin
                tcu_pop <= {{(NUM_Q-1){1'b0}}, 1'b1} << gnt_idx;
                pop_qid <= gnt_idx;
                ptr     <= (gnt_idx == QID_W'(NUM_Q - 1)) ? '0 : gnt_idx + 1'b1;
            end

            pipe_v[0] <= |tcu_pop;
            pipe_q[0] <= pop_qid;
            for (int s = 1; s < POP_LAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_q[s] <= pipe_q[s-1];
            end

            credit <= credit_nxt;

            if (fifo_wr)
                wptr <= wptr + 1'b1;
            if (fifo_rd)
                rptr <= rptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (ret_unexp)
                err_unexp <= 1'b1;
            if (ret_miss)
                err_miss <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fifo_wr) begin
            mem_d[wptr] <= tqu_data;
            mem_q[wptr] <= exp_qid;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr && !fifo_rd && (fifo_cnt == CRED_W'(FIFO_DEPTH))));

    a_pop_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(tcu_pop));

endmodule
